// File: rtl/paralelo_serial_tx_param.sv
`default_nettype none
// ============================================================================
//  Module   : paralelo_serial_tx_param
//  Purpose  : Parametrised parallel-to-serial lane transmitter. Takes WIDTH-bit
//             words over valid/ready, shifts them out one bit per clock, fills
//             empty slots with IDLE_WORD and sends SYNC_WORDS idle words after
//             every reset before data is accepted.
//  Revision : 1.0  initial release
// ============================================================================
module paralelo_serial_tx_param #(
  parameter int                WIDTH      = 8,
  parameter logic [WIDTH-1:0]  IDLE_WORD  = WIDTH'(8'hBC),
  parameter bit                MSB_FIRST  = 1'b1,
  parameter int                SYNC_WORDS = 4
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active low
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             serial_out,
  output logic             word_start,
  output logic             idle_out,
  output logic             sync_done
);

  localparam int                CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIDTH - 1);
  localparam int                SYNC_W    = $clog2(SYNC_WORDS + 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              idle_q, idle_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic              boundary;

  // The counter is preset to the last bit so the first edge after reset
  // release is a word boundary and loads the first sync idle word.
  assign boundary = (cnt_q == LAST_CNT);

  // State, bit counter, shift register and idle flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SYNC;
      cnt_q      <= LAST_CNT;
      shift_q    <= '0;
      idle_q     <= 1'b0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      idle_q     <= idle_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  // Next-state: free-running bit counter, word load at boundaries, shift otherwise.
  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    sync_cnt_d = sync_cnt_q;
    cnt_d      = boundary ? '0 : cnt_q + 1'b1;
    ready_out  = 1'b0;

    // Between boundaries the next transmit bit moves into the output position.
    if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
    end

    case (state_q)
      ST_SYNC: begin
        if (boundary) begin
          shift_d    = IDLE_WORD;
          idle_d     = 1'b1;
          sync_cnt_d = sync_cnt_q + 1'b1;
          // Entering RUN while the last sync word loads lets the very next
          // boundary accept data, so exactly SYNC_WORDS idles precede data.
          if (sync_cnt_q == SYNC_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        ready_out = boundary;
        if (boundary) begin
          if (valid_in) begin
            shift_d = data_in;
            idle_d  = 1'b0;
          end else begin
            shift_d = IDLE_WORD;
            idle_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  assign serial_out = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign word_start = (cnt_q == '0);
  assign idle_out   = idle_q;
  assign sync_done  = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_paralelo_serial_tx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_paralelo_serial_tx_param
//  Purpose  : Self-checking bench for paralelo_serial_tx_param. Three
//             configurations (8-bit MSB-first, 8-bit LSB-first, 10-bit with a
//             single sync word) are exercised one at a time; expected per-cycle
//             output vectors are queued as words are offered and compared as
//             the DUT shifts them out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_paralelo_serial_tx_param;

  logic       clk = 1'b0;
  logic [2:0] rstn;
  logic       valid_in;
  logic [9:0] data_in;
  logic [1:0] sel;

  logic ready_a, ser_a, ws_a, idle_a, sd_a;
  logic ready_b, ser_b, ws_b, idle_b, sd_b;
  logic ready_c, ser_c, ws_c, idle_c, sd_c;

  // Observed vector of the selected DUT: {serial, word_start, idle, ready, sync_done}
  logic [4:0] obs;

  // Scoreboard of expected per-cycle vectors
  logic [4:0] exp_q[$];
  logic [4:0] mon_exp;
  bit         mon_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  // Current configuration under test
  int          cw;
  bit          cmsb;
  int          cs;
  logic [31:0] cidle;
  int          wi;

  always #5 clk = ~clk;

  paralelo_serial_tx_param #(.WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1), .SYNC_WORDS(4)) u_dut_a (
    .clk(clk), .reset(rstn[0]), .data_in(data_in[7:0]), .valid_in(valid_in),
    .ready_out(ready_a), .serial_out(ser_a), .word_start(ws_a), .idle_out(idle_a), .sync_done(sd_a)
  );

  paralelo_serial_tx_param #(.WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b0), .SYNC_WORDS(4)) u_dut_b (
    .clk(clk), .reset(rstn[1]), .data_in(data_in[7:0]), .valid_in(valid_in),
    .ready_out(ready_b), .serial_out(ser_b), .word_start(ws_b), .idle_out(idle_b), .sync_done(sd_b)
  );

  paralelo_serial_tx_param #(.WIDTH(10), .IDLE_WORD(10'h17C), .MSB_FIRST(1'b1), .SYNC_WORDS(1)) u_dut_c (
    .clk(clk), .reset(rstn[2]), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_c), .serial_out(ser_c), .word_start(ws_c), .idle_out(idle_c), .sync_done(sd_c)
  );

  always_comb begin
    obs = '0;
    case (sel)
      2'd0:    obs = {ser_a, ws_a, idle_a, ready_a, sd_a};
      2'd1:    obs = {ser_b, ws_b, idle_b, ready_b, sd_b};
      2'd2:    obs = {ser_c, ws_c, idle_c, ready_c, sd_c};
      default: obs = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [4:0] o, input logic [4:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (ser,ws,idle,rdy,sync) word %0d", tag, o, e, wi);
    end
  endtask

  // Output monitor: samples 2 ns after each rising edge
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL scoreboard_underflow: observed %b expected none", obs);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("bit", obs, mon_exp);
      end
    end
  end

  // Hold every DUT in reset, check reset outputs, release the selected one at a
  // falling edge so the next rising edge is the first word boundary.
  task automatic start(input logic [1:0] s, input int w, input bit msb, input int sw,
                       input logic [31:0] idle, input bit v, input logic [31:0] d);
    mon_en   = 1'b0;
    sel      = s;
    cw       = w;
    cmsb     = msb;
    cs       = sw;
    cidle    = idle;
    wi       = 0;
    valid_in = v;
    data_in  = d[9:0];
    rstn     = 3'b000;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("reset_hold", obs, 5'b0);
    rstn[s] = 1'b1;
    #1;
    chk("reset_release", obs, 5'b0);
    mon_en = 1'b1;
  endtask

  // Offer one word slot at the falling edge before a boundary and queue the
  // expected output for the WIDTH cycles that follow. With mid set, a stray
  // valid pulse is driven while ready is low; it must not produce a word.
  task automatic slot(input bit v, input logic [31:0] d, input bit mid);
    logic [31:0] w;
    bit          isidle;
    bit          sd;
    valid_in = v;
    data_in  = d[9:0];
    isidle   = (wi < cs) || !v;
    w        = isidle ? cidle : d;
    sd       = (wi >= cs - 1);
    for (int k = 0; k < cw; k++) begin
      int idx;
      idx = cmsb ? (cw - 1 - k) : k;
      exp_q.push_back({w[idx], (k == 0), isidle, (sd && (k == cw - 1)), sd});
    end
    wi++;
    @(negedge clk);
    if (mid) begin
      valid_in = 1'b1;
      data_in  = 10'h0A5;
      repeat (2) @(negedge clk);
      valid_in = 1'b0;
      repeat (cw - 3) @(negedge clk);
    end else begin
      repeat (cw - 1) @(negedge clk);
    end
  endtask

  // Data word interrupted by reset during its bit-3 cycle
  task automatic slot_abort(input logic [31:0] d);
    valid_in = 1'b1;
    data_in  = d[9:0];
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = cmsb ? (cw - 1 - k) : k;
      exp_q.push_back({d[idx], (k == 0), 1'b0, 1'b0, 1'b1});
    end
    wi++;
    repeat (4) @(negedge clk);
    mon_en     = 1'b0;
    rstn[sel]  = 1'b0;
    #1;
    chk("async_reset", obs, 5'b0);
  endtask

  task automatic finish_dut(input string tag);
    mon_en = 1'b0;
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL %s_drain: observed %0d pending expected 0", tag, exp_q.size());
    end
  endtask

  initial begin
    sel      = 2'd0;
    rstn     = 3'b000;
    valid_in = 1'b0;
    data_in  = '0;

    // 8-bit MSB first: valid held from reset, then RUN patterns
    start(2'd0, 8, 1'b1, 4, 32'hBC, 1'b1, 32'h7C);
    repeat (4) slot(1'b1, 32'h7C, 1'b0);
    repeat (2) slot(1'b1, 32'h7C, 1'b0);
    slot(1'b0, 32'h00, 1'b0);
    slot(1'b1, 32'hA5, 1'b0);
    slot(1'b0, 32'h00, 1'b0);
    slot(1'b0, 32'h00, 1'b1);
    slot(1'b1, 32'hBC, 1'b0);
    slot(1'b0, 32'h00, 1'b0);
    slot_abort(32'h5A);
    // Full resync after a mid-word reset
    start(2'd0, 8, 1'b1, 4, 32'hBC, 1'b1, 32'h7C);
    repeat (4) slot(1'b1, 32'h7C, 1'b0);
    slot(1'b1, 32'h7C, 1'b0);
    slot(1'b0, 32'h00, 1'b0);
    finish_dut("msb8");

    // 8-bit LSB first
    start(2'd1, 8, 1'b0, 4, 32'hBC, 1'b0, 32'h00);
    repeat (4) slot(1'b0, 32'h00, 1'b0);
    slot(1'b1, 32'hBC, 1'b0);
    slot(1'b1, 32'h01, 1'b0);
    slot(1'b0, 32'h00, 1'b0);
    finish_dut("lsb8");

    // 10-bit, single sync word, back-to-back data
    start(2'd2, 10, 1'b1, 1, 32'h17C, 1'b0, 32'h00);
    slot(1'b0, 32'h000, 1'b0);
    slot(1'b1, 32'h3FF, 1'b0);
    slot(1'b1, 32'h000, 1'b0);
    slot(1'b0, 32'h000, 1'b0);
    slot(1'b1, 32'h155, 1'b0);
    finish_dut("w10");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected summary");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
